// File: rtl/v_mem_ld_2_if.sv
// Memory read port of the vector load engine: req/gnt address phase
// followed by a single rvalid data beat per granted request.
interface v_mem_ld_2_if #(
   parameter int MEM_DW = 64,
   parameter int MEM_AW = 32
);
   logic              mem_req_o;
   logic [MEM_AW-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [MEM_DW-1:0] mem_rdata_i;

   // load engine side
   modport master (
      output mem_req_o,
      output mem_addr_o,
      input  mem_gnt_i,
      input  mem_rvalid_i,
      input  mem_rdata_i
   );

   // memory side
   modport slave (
      input  mem_req_o,
      input  mem_addr_o,
      output mem_gnt_i,
      output mem_rvalid_i,
      output mem_rdata_i
   );
endinterface

// File: rtl/v_mem_ld_2.sv
// Vector unit-stride load engine. Fetches one vector register as NBEAT
// memory beats (one outstanding request at a time), assembles them
// least-significant lane first, then issues a single-cycle writeback.
module v_mem_ld_2 #(
   parameter int VREG_DW = 256,
   parameter int VREG_AW = 5,
   parameter int MEM_DW  = 64,
   parameter int MEM_AW  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld_req_i,
   input  logic [MEM_AW-1:0]  vld_addr_i,
   input  logic [VREG_AW-1:0] vld_vd_i,
   output logic               vld_busy_o,
   v_mem_ld_2_if.master       mem,
   output logic               vid_wb_en_o,
   output logic [VREG_AW-1:0] vid_wb_addr_o,
   output logic [VREG_DW-1:0] vmem_result_o
);

   localparam int NBEAT  = VREG_DW / MEM_DW;
   localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam int OFF_W  = $clog2(MEM_DW / 8);

   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NBEAT - 1);
   localparam logic [MEM_AW-1:0] ALIGN_MASK = {{(MEM_AW-OFF_W){1'b1}}, {OFF_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   state_t              state_r;
   state_t              next_state_s;

   logic [MEM_AW-1:0]   base_r;
   logic [MEM_AW-1:0]   base_s;
   logic [VREG_AW-1:0]  vd_r;
   logic [VREG_AW-1:0]  vd_s;
   logic [BEAT_W-1:0]   beat_r;
   logic [BEAT_W-1:0]   beat_s;
   logic [VREG_DW-1:0]  data_r;
   logic [VREG_DW-1:0]  data_s;
   logic [MEM_AW-1:0]   addr_r;
   logic [MEM_AW-1:0]   addr_s;
   logic                busy_r;
   logic                req_r;
   logic                wb_en_r;

   // state register; reset abandons any transfer in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (vld_req_i) begin
               next_state_s = ST_REQ;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem.mem_gnt_i) begin
               next_state_s = ST_WAIT;
            end else begin
               next_state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem.mem_rvalid_i) begin
               if (beat_r == LAST_BEAT) begin
                  next_state_s = ST_WB;
               end else begin
                  next_state_s = ST_REQ;
               end
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_WB: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // next values of the datapath and of the registered outputs
   always_comb begin
      base_s = base_r;
      vd_s   = vd_r;
      beat_s = beat_r;
      data_s = data_r;
      case (state_r)
         ST_IDLE: begin
            if (vld_req_i) begin
               base_s = vld_addr_i & ALIGN_MASK;
               vd_s   = vld_vd_i;
               beat_s = {BEAT_W{1'b0}};
               data_s = {VREG_DW{1'b0}};
            end else begin
               base_s = base_r;
            end
         end
         ST_WAIT: begin
            if (mem.mem_rvalid_i) begin
               data_s[int'(beat_r)*MEM_DW +: MEM_DW] = mem.mem_rdata_i;
               if (beat_r != LAST_BEAT) begin
                  beat_s = beat_r + BEAT_W'(1);
               end else begin
                  beat_s = beat_r;
               end
            end else begin
               data_s = data_r;
            end
         end
         default: begin
            data_s = data_r;
         end
      endcase
      // beat address wraps modulo 2^MEM_AW by construction
      addr_s = base_s + (MEM_AW'(beat_s) << OFF_W);
   end

   // datapath and output registers; address only moves when entering REQ
   always_ff @(posedge clk) begin
      if (!rst) begin
         base_r  <= {MEM_AW{1'b0}};
         vd_r    <= {VREG_AW{1'b0}};
         beat_r  <= {BEAT_W{1'b0}};
         data_r  <= {VREG_DW{1'b0}};
         addr_r  <= {MEM_AW{1'b0}};
         busy_r  <= 1'b0;
         req_r   <= 1'b0;
         wb_en_r <= 1'b0;
      end else begin
         base_r  <= base_s;
         vd_r    <= vd_s;
         beat_r  <= beat_s;
         data_r  <= data_s;
         busy_r  <= (next_state_s != ST_IDLE);
         req_r   <= (next_state_s == ST_REQ);
         wb_en_r <= (next_state_s == ST_WB);
         if (next_state_s == ST_REQ) begin
            addr_r <= addr_s;
         end else begin
            addr_r <= addr_r;
         end
      end
   end

   assign vld_busy_o     = busy_r;
   assign mem.mem_req_o  = req_r;
   assign mem.mem_addr_o = addr_r;
   assign vid_wb_en_o    = wb_en_r;
   assign vid_wb_addr_o  = vd_r;
   assign vmem_result_o  = data_r;

endmodule

// File: tb/tb_v_mem_ld_2.sv
// Directed bench for v_mem_ld_2: inputs driven and outputs sampled on
// the falling edge; the bench acts as the memory with per-beat delays.
module tb_v_mem_ld_2;

   logic         clk = 1'b0;
   logic         rst;
   logic         vld_req_i;
   logic [31:0]  vld_addr_i;
   logic [4:0]   vld_vd_i;
   logic         vld_busy_o;
   logic         vid_wb_en_o;
   logic [4:0]   vid_wb_addr_o;
   logic [255:0] vmem_result_o;

   v_mem_ld_2_if #(.MEM_DW(64), .MEM_AW(32)) mem_if ();

   v_mem_ld_2 dut (
      .clk           (clk),
      .rst           (rst),
      .vld_req_i     (vld_req_i),
      .vld_addr_i    (vld_addr_i),
      .vld_vd_i      (vld_vd_i),
      .vld_busy_o    (vld_busy_o),
      .mem           (mem_if),
      .vid_wb_en_o   (vid_wb_en_o),
      .vid_wb_addr_o (vid_wb_addr_o),
      .vmem_result_o (vmem_result_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // per-load memory behaviour
   logic [63:0]  bd [4];
   int           gd [4];
   int           rd [4];
   int           busy_at;
   bit           accept_after;
   // per-load observations
   logic [31:0]  sa [4];
   int           wb_cycle;
   int           wb_pulses;
   logic [4:0]   wb_vd;
   logic [255:0] wb_data;
   bit           unstable;
   bit           req_in_wait;
   logic         busy_after;
   logic         busy_next;
   logic [255:0] res_k1;
   logic [255:0] res_next;

   task automatic clear_cfg();
      for (int i = 0; i < 4; i++) begin
         gd[i] = 0;
         rd[i] = 0;
      end
      busy_at      = -1;
      accept_after = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [4:0] vd);
      int b;
      int phase;
      int cnt;
      b = 0; phase = 0; cnt = 0;
      wb_cycle = -1; wb_pulses = 0; unstable = 1'b0; req_in_wait = 1'b0;
      busy_after = 1'b1; busy_next = 1'b0;
      res_k1 = '1; res_next = '1; wb_vd = '0; wb_data = '0;
      for (int i = 0; i < 4; i++) sa[i] = 32'hDEAD_BEEF;
      @(negedge clk);
      vld_req_i = 1'b1; vld_addr_i = addr; vld_vd_i = vd;
      for (int k = 1; k <= 120; k++) begin
         @(negedge clk);
         vld_req_i = 1'b0;
         mem_if.mem_gnt_i = 1'b0;
         mem_if.mem_rvalid_i = 1'b0;
         mem_if.mem_rdata_i = 64'h0;
         if (k == busy_at) begin
            vld_req_i = 1'b1; vld_addr_i = 32'h0000_5000; vld_vd_i = 5'd7;
         end
         if (k == 1) res_k1 = vmem_result_o;
         if (vid_wb_en_o) begin
            wb_pulses++;
            if (wb_cycle < 0) begin
               wb_cycle = k; wb_vd = vid_wb_addr_o; wb_data = vmem_result_o;
            end
         end
         if (wb_cycle >= 0 && k == wb_cycle + 1) begin
            busy_after = vld_busy_o;
            if (accept_after) begin
               vld_req_i = 1'b1; vld_addr_i = 32'h0000_2000; vld_vd_i = 5'd5;
            end
         end
         if (wb_cycle >= 0 && k == wb_cycle + 2) begin
            busy_next = vld_busy_o; res_next = vmem_result_o;
         end
         case (phase)
            0: begin
               if (mem_if.mem_req_o) begin
                  if (cnt == 0) sa[b] = mem_if.mem_addr_o;
                  else if (mem_if.mem_addr_o !== sa[b]) unstable = 1'b1;
                  if (cnt == gd[b]) begin
                     mem_if.mem_gnt_i = 1'b1; phase = 1; cnt = 0;
                  end else begin
                     cnt++;
                  end
               end
            end
            1: begin
               if (mem_if.mem_req_o) req_in_wait = 1'b1;
               if (cnt == rd[b]) begin
                  mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = bd[b];
                  b++; cnt = 0; phase = (b == 4) ? 2 : 0;
               end else begin
                  cnt++;
               end
            end
            default: ;
         endcase
         if (wb_cycle >= 0 && k >= wb_cycle + 2) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (vld_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", vld_busy_o); end
      checks++; if (mem_if.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_if.mem_req_o); end
      checks++; if (mem_if.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_if.mem_addr_o); end
      checks++; if (vid_wb_en_o !== 1'b0) begin errors++; $display("FAIL rst_wb_en: got %b expected 0", vid_wb_en_o); end
      checks++; if (vid_wb_addr_o !== 5'd0) begin errors++; $display("FAIL rst_wb_addr: got %0d expected 0", vid_wb_addr_o); end
      checks++; if (vmem_result_o !== 256'h0) begin errors++; $display("FAIL rst_result: got %h expected 0", vmem_result_o); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero_wait();
      logic [31:0] ea [4];
      ea[0] = 32'h1000; ea[1] = 32'h1008; ea[2] = 32'h1010; ea[3] = 32'h1018;
      clear_cfg();
      bd[0] = 64'h1111_1111_1111_1111; bd[1] = 64'h2222_2222_2222_2222;
      bd[2] = 64'h3333_3333_3333_3333; bd[3] = 64'h4444_4444_4444_4444;
      do_load(32'h0000_1000, 5'd3);
      for (int i = 0; i < 4; i++) begin
         checks++; if (sa[i] !== ea[i]) begin errors++; $display("FAIL zw_addr%0d: got %h expected %h", i, sa[i], ea[i]); end
      end
      checks++; if (wb_cycle !== 9) begin errors++; $display("FAIL zw_latency: got %0d expected 9", wb_cycle); end
      checks++; if (wb_pulses !== 1) begin errors++; $display("FAIL zw_pulses: got %0d expected 1", wb_pulses); end
      checks++; if (wb_vd !== 5'd3) begin errors++; $display("FAIL zw_vd: got %0d expected 3", wb_vd); end
      checks++;
      if (wb_data !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
         errors++; $display("FAIL zw_data: got %h", wb_data);
      end
      checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL zw_busy_after: got %b expected 0", busy_after); end
      checks++; if (res_k1 !== 256'h0) begin errors++; $display("FAIL zw_clear: got %h expected 0", res_k1); end
   endtask

   task automatic test_backpressure();
      clear_cfg();
      gd[1] = 3; rd[2] = 2;
      do_load(32'h0000_1000, 5'd3);
      checks++; if (sa[1] !== 32'h1008) begin errors++; $display("FAIL bp_addr1: got %h expected 00001008", sa[1]); end
      checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL bp_addr_stable: got %b expected 0", unstable); end
      checks++; if (req_in_wait !== 1'b0) begin errors++; $display("FAIL bp_req_in_wait: got %b expected 0", req_in_wait); end
      checks++; if (wb_cycle !== 14) begin errors++; $display("FAIL bp_latency: got %0d expected 14", wb_cycle); end
      checks++;
      if (wb_data !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
         errors++; $display("FAIL bp_data: got %h", wb_data);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] ea [4];
      ea[0] = 32'hFFFF_FFF8; ea[1] = 32'h0000_0000; ea[2] = 32'h0000_0008; ea[3] = 32'h0000_0010;
      clear_cfg();
      do_load(32'hFFFF_FFFB, 5'd9);
      for (int i = 0; i < 4; i++) begin
         checks++; if (sa[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, sa[i], ea[i]); end
      end
      checks++; if (wb_vd !== 5'd9) begin errors++; $display("FAIL wrap_vd: got %0d expected 9", wb_vd); end
   endtask

   task automatic test_busy();
      clear_cfg();
      busy_at = 3; accept_after = 1'b1;
      do_load(32'h0000_1000, 5'd3);
      checks++; if (wb_vd !== 5'd3) begin errors++; $display("FAIL busy_vd: got %0d expected 3", wb_vd); end
      checks++; if (sa[3] !== 32'h1018) begin errors++; $display("FAIL busy_addr3: got %h expected 00001018", sa[3]); end
      checks++; if (wb_pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d expected 1", wb_pulses); end
      checks++; if (busy_next !== 1'b1) begin errors++; $display("FAIL busy_accept: got %b expected 1", busy_next); end
      checks++; if (res_next !== 256'h0) begin errors++; $display("FAIL busy_clear: got %h expected 0", res_next); end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit saw_wb;
      bit saw_busy;
      bit saw_data;
      saw_wb = 1'b0; saw_busy = 1'b0; saw_data = 1'b0;
      @(negedge clk);
      vld_req_i = 1'b1; vld_addr_i = 32'h0000_3000; vld_vd_i = 5'd4;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         vld_req_i = 1'b0;
         mem_if.mem_gnt_i = (k % 2 == 1);
         mem_if.mem_rvalid_i = (k % 2 == 0);
         mem_if.mem_rdata_i = 64'hCAFE_0000_0000_0000 + 64'(k);
      end
      @(negedge clk);
      mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
      checks++; if (vld_busy_o !== 1'b1) begin errors++; $display("FAIL rm_in_wait: got %b expected 1", vld_busy_o); end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
      checks++; if (vld_busy_o !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", vld_busy_o); end
      checks++; if (mem_if.mem_req_o !== 1'b0 || mem_if.mem_addr_o !== 32'h0) begin
         errors++; $display("FAIL rm_mem: got req=%b addr=%h expected 0/0", mem_if.mem_req_o, mem_if.mem_addr_o);
      end
      checks++; if (vmem_result_o !== 256'h0 || vid_wb_addr_o !== 5'd0) begin
         errors++; $display("FAIL rm_wb_regs: got data=%h vd=%0d expected 0", vmem_result_o, vid_wb_addr_o);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         mem_if.mem_rvalid_i = 1'b0;
         if (vid_wb_en_o) saw_wb = 1'b1;
         if (vld_busy_o) saw_busy = 1'b1;
         if (vmem_result_o !== 256'h0) saw_data = 1'b1;
      end
      checks++; if (saw_wb !== 1'b0) begin errors++; $display("FAIL rm_no_wb: got %b expected 0", saw_wb); end
      checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL rm_idle: got %b expected 0", saw_busy); end
      checks++; if (saw_data !== 1'b0) begin errors++; $display("FAIL rm_stale_rvalid: got %b expected 0", saw_data); end
   endtask

   task automatic test_back_to_back();
      clear_cfg();
      bd[0] = 64'hA0A0_A0A0_A0A0_A0A0; bd[1] = 64'hA1A1_A1A1_A1A1_A1A1;
      bd[2] = 64'hA2A2_A2A2_A2A2_A2A2; bd[3] = 64'hA3A3_A3A3_A3A3_A3A3;
      do_load(32'h0000_4000, 5'd1);
      checks++; if (wb_vd !== 5'd1 || wb_pulses !== 1) begin errors++; $display("FAIL b2b_first_wb: got vd=%0d pulses=%0d expected 1/1", wb_vd, wb_pulses); end
      checks++;
      if (wb_data !== 256'hA3A3A3A3A3A3A3A3_A2A2A2A2A2A2A2A2_A1A1A1A1A1A1A1A1_A0A0A0A0A0A0A0A0) begin
         errors++; $display("FAIL b2b_first_data: got %h", wb_data);
      end
      bd[0] = 64'h0000_0000_0000_00B0; bd[1] = 64'h0000_0000_0000_00B1;
      bd[2] = 64'h0000_0000_0000_00B2; bd[3] = 64'h0000_0000_0000_00B3;
      do_load(32'h0000_6000, 5'd2);
      checks++; if (res_k1 !== 256'h0) begin errors++; $display("FAIL b2b_clear: got %h expected 0", res_k1); end
      checks++; if (wb_vd !== 5'd2 || wb_pulses !== 1) begin errors++; $display("FAIL b2b_second_wb: got vd=%0d pulses=%0d expected 2/1", wb_vd, wb_pulses); end
      checks++;
      if (wb_data !== 256'h00000000000000B3_00000000000000B2_00000000000000B1_00000000000000B0) begin
         errors++; $display("FAIL b2b_second_data: got %h", wb_data);
      end
   endtask

   initial begin
      rst = 1'b0;
      vld_req_i = 1'b0; vld_addr_i = 32'h0; vld_vd_i = 5'd0;
      mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = 64'h0;
      clear_cfg();
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_wrap();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
